// File: rtl/bus_uart_pkg.sv
// Shared definitions for the bus-attached UART: register offsets,
// STATUS bit positions and the transmitter state encoding.
package bus_uart_pkg;

    localparam logic [3:0] UART_DATA_OFS   = 4'h0;
    localparam logic [3:0] UART_STATUS_OFS = 4'h4;
    localparam logic [3:0] UART_DIV_OFS    = 4'h8;

    localparam int STAT_BUSY_BIT    = 0;
    localparam int STAT_FULL_BIT    = 1;
    localparam int STAT_EMPTY_BIT   = 2;
    localparam int STAT_OVERRUN_BIT = 3;
    localparam int STAT_LEVEL_LSB   = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } uart_tx_state_t;

endpackage

// File: rtl/bus_uart_tx_if.sv
// Core load/store bus as seen by a memory-mapped slave. Reads are
// combinational; a non-selected slave drives zero so slaves can be OR-ed.
interface bus_uart_tx_if;

    logic [31:0] bus_address;
    logic [31:0] bus_write_data;
    logic        bus_write;
    logic        bus_read;
    logic [31:0] bus_read_data;

    modport master (
        output bus_address,
        output bus_write_data,
        output bus_write,
        output bus_read,
        input  bus_read_data
    );

    modport slave (
        input  bus_address,
        input  bus_write_data,
        input  bus_write,
        input  bus_read,
        output bus_read_data
    );

endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count. Push when full and pop when
// empty are ignored. DEPTH must be a power of two so pointers wrap freely.
module sync_fifo #(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 4,
    localparam int AW    = $clog2(DEPTH),
    localparam int LW    = AW + 1
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [LW-1:0]    level_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [LW-1:0]    level_q;
    logic             do_push;
    logic             do_pop;

    assign full_o  = (level_q == LW'(DEPTH));
    assign empty_o = (level_q == '0);
    assign level_o = level_q;
    assign rdata_o = mem_q[rd_ptr_q];
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    // Storage array; contents are don't-care until written, so no reset.
    always_ff @(posedge clock) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    // Pointers and occupancy.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            level_q <= level_q + LW'(do_push) - LW'(do_pop);
        end
    end

endmodule

// File: rtl/bus_uart_tx.sv
// Memory-mapped UART transmitter: DATA/STATUS/DIVISOR registers, a TX FIFO
// and an 8N1 serialiser. Optional parity is enabled by defining
// BUS_UART_TX_PARITY_EN (adds a parity bit; DIVISOR[16] selects odd parity).
//
// state     | meaning
// ----------+-----------------------------------------------
// ST_IDLE   | line high, waiting for a byte in the FIFO
// ST_START  | start bit (line low)
// ST_DATA   | 8 data bits, LSB first
// ST_PARITY | parity bit (parity build only)
// ST_STOP   | stop bit (line high); chains into next frame
module bus_uart_tx
    import bus_uart_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR       = 32'h1000_0000,
    parameter int          FIFO_DEPTH      = 4,
    parameter logic [15:0] DEFAULT_DIVISOR = 16'd868
) (
    input  logic          clock,
    input  logic          reset_n,
    bus_uart_tx_if.slave  bus,
    output logic          tx
);

    localparam int LW = $clog2(FIFO_DEPTH) + 1;

    uart_tx_state_t state_q, state_d;
    logic [15:0]    timer_q, timer_d;
    logic [2:0]     bit_cnt_q, bit_cnt_d;
    logic [7:0]     shift_q, shift_d;
    logic           overrun_q, overrun_d;
    logic [15:0]    divisor_q, divisor_d;
`ifdef BUS_UART_TX_PARITY_EN
    logic           par_q, par_d;
    logic           odd_q, odd_d;
`endif

    logic          sel;
    logic [3:0]    ofs;
    logic          wr_data;
    logic          wr_status;
    logic          wr_div;
    logic          fifo_push;
    logic          fifo_pop;
    logic          fifo_full;
    logic          fifo_empty;
    logic [LW-1:0] fifo_level;
    logic [7:0]    fifo_head;
    logic [15:0]   div_m1;
    logic          bit_done;
    logic [31:0]   status;
    logic          unused_ok;

    assign sel       = (bus.bus_address[31:4] == BASE_ADDR[31:4]);
    assign ofs       = bus.bus_address[3:0];
    assign wr_data   = bus.bus_write && sel && (ofs == UART_DATA_OFS);
    assign wr_status = bus.bus_write && sel && (ofs == UART_STATUS_OFS);
    assign wr_div    = bus.bus_write && sel && (ofs == UART_DIV_OFS);
    // Fullness is judged before any same-cycle pop, so a full FIFO drops the byte.
    assign fifo_push = wr_data && !fifo_full;
    assign div_m1    = divisor_q - 16'd1;
    assign bit_done  = (timer_q == 16'h0);
    assign unused_ok = ^bus.bus_write_data[31:16];

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock   (clock),
        .reset_n (reset_n),
        .push_i  (fifo_push),
        .pop_i   (fifo_pop),
        .wdata_i (bus.bus_write_data[7:0]),
        .rdata_o (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .level_o (fifo_level)
    );

    // Register-side next state: sticky overrun (set beats clear) and divisor.
    always_comb begin
        overrun_d = overrun_q;
        divisor_d = divisor_q;
`ifdef BUS_UART_TX_PARITY_EN
        odd_d     = odd_q;
`endif
        if (wr_status && bus.bus_write_data[STAT_OVERRUN_BIT]) begin
            overrun_d = 1'b0;
        end
        if (wr_data && fifo_full) begin
            overrun_d = 1'b1;
        end
        if (wr_div) begin
            divisor_d = (bus.bus_write_data[15:0] == 16'h0) ? 16'h1 : bus.bus_write_data[15:0];
`ifdef BUS_UART_TX_PARITY_EN
            odd_d     = bus.bus_write_data[16];
`endif
        end
    end

    // Serialiser next state; every bit reloads the timer from the current divisor.
    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        fifo_pop  = 1'b0;
`ifdef BUS_UART_TX_PARITY_EN
        par_d     = par_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    state_d  = ST_START;
                    timer_d  = div_m1;
                    shift_d  = fifo_head;
`ifdef BUS_UART_TX_PARITY_EN
                    par_d    = ^fifo_head;
`endif
                end
            end
            ST_START: begin
                if (bit_done) begin
                    state_d   = ST_DATA;
                    timer_d   = div_m1;
                    bit_cnt_d = 3'd0;
                end else begin
                    timer_d = timer_q - 16'd1;
                end
            end
            ST_DATA: begin
                if (bit_done) begin
                    timer_d = div_m1;
                    shift_d = {1'b0, shift_q[7:1]};
                    if (bit_cnt_q == 3'd7) begin
`ifdef BUS_UART_TX_PARITY_EN
                        state_d = ST_PARITY;
`else
                        state_d = ST_STOP;
`endif
                    end else begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                    end
                end else begin
                    timer_d = timer_q - 16'd1;
                end
            end
`ifdef BUS_UART_TX_PARITY_EN
            ST_PARITY: begin
                if (bit_done) begin
                    state_d = ST_STOP;
                    timer_d = div_m1;
                end else begin
                    timer_d = timer_q - 16'd1;
                end
            end
`endif
            ST_STOP: begin
                if (bit_done) begin
                    if (!fifo_empty) begin
                        fifo_pop = 1'b1;
                        state_d  = ST_START;
                        timer_d  = div_m1;
                        shift_d  = fifo_head;
`ifdef BUS_UART_TX_PARITY_EN
                        par_d    = ^fifo_head;
`endif
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    timer_d = timer_q - 16'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State registers; reset aborts any frame in flight.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            timer_q   <= 16'h0;
            bit_cnt_q <= 3'd0;
            shift_q   <= 8'h0;
            overrun_q <= 1'b0;
            divisor_q <= DEFAULT_DIVISOR;
`ifdef BUS_UART_TX_PARITY_EN
            par_q     <= 1'b0;
            odd_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            overrun_q <= overrun_d;
            divisor_q <= divisor_d;
`ifdef BUS_UART_TX_PARITY_EN
            par_q     <= par_d;
            odd_q     <= odd_d;
`endif
        end
    end

    // Line level decoded from state so reset forces the idle level at once.
    always_comb begin
        tx = 1'b1;
        case (state_q)
            ST_START:  tx = 1'b0;
            ST_DATA:   tx = shift_q[0];
`ifdef BUS_UART_TX_PARITY_EN
            ST_PARITY: tx = par_q ^ odd_q;
`endif
            default:   tx = 1'b1;
        endcase
    end

    // STATUS word assembly.
    always_comb begin
        status                          = 32'h0;
        status[STAT_BUSY_BIT]           = (state_q != ST_IDLE);
        status[STAT_FULL_BIT]           = fifo_full;
        status[STAT_EMPTY_BIT]          = fifo_empty;
        status[STAT_OVERRUN_BIT]        = overrun_q;
        status[STAT_LEVEL_LSB +: 8]     = 8'(fifo_level);
    end

    // Combinational read mux; zero when not addressed so slaves can be OR-ed.
    always_comb begin
        bus.bus_read_data = 32'h0;
        if (bus.bus_read && sel) begin
            case (ofs)
                UART_STATUS_OFS: bus.bus_read_data = status;
`ifdef BUS_UART_TX_PARITY_EN
                UART_DIV_OFS:    bus.bus_read_data = {15'h0, odd_q, divisor_q};
`else
                UART_DIV_OFS:    bus.bus_read_data = {16'h0, divisor_q};
`endif
                default:         bus.bus_read_data = 32'h0;
            endcase
        end
    end

endmodule

// File: tb/tb_bus_uart_tx.sv
// Randomised scoreboard bench for bus_uart_tx: writes push expected frames
// into a queue; an independent line monitor pops and checks every bit-cycle.
`timescale 1ns/1ps
module tb_bus_uart_tx;

    localparam logic [31:0] BASE   = 32'h1000_0000;
    localparam logic [31:0] A_DATA = BASE + 32'h0;
    localparam logic [31:0] A_STAT = BASE + 32'h4;
    localparam logic [31:0] A_DIV  = BASE + 32'h8;
`ifdef BUS_UART_TX_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif

    logic clock   = 1'b0;
    logic reset_n = 1'b0;
    logic tx;

    bus_uart_tx_if bus ();

    bus_uart_tx #(
        .BASE_ADDR       (BASE),
        .FIFO_DEPTH      (4),
        .DEFAULT_DIVISOR (16'd868)
    ) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus),
        .tx      (tx)
    );

    always #5 clock = ~clock;

    int unsigned cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    typedef struct {
        logic [7:0] data;
        int         div;
    } frame_t;

    int          errors  = 0;
    int          checks  = 0;
    frame_t      exp_q[$];
    int unsigned starts[$];
    bit          abort_ok = 1'b0;
    int          cur_div  = 868;

    // Expected line level for bit slot n of a frame carrying byte b.
    function automatic logic exp_level(input logic [7:0] b, input int n);
        if (n == 0) return 1'b0;
        if (n <= 8) return b[n-1];
`ifdef BUS_UART_TX_PARITY_EN
        if (n == 9) return ^b;
`endif
        return 1'b1;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        bus.bus_address    = a;
        bus.bus_write_data = d;
        bus.bus_write      = 1'b1;
        bus.bus_read       = 1'b0;
        @(posedge clock);
        #1;
        bus.bus_write = 1'b0;
    endtask

    task automatic rd(input logic [31:0] a, output logic [31:0] d);
        bus.bus_address = a;
        bus.bus_read    = 1'b1;
        #1;
        d            = bus.bus_read_data;
        bus.bus_read = 1'b0;
    endtask

    task automatic wr_div(input logic [31:0] v);
        wr(A_DIV, v);
        cur_div = (v[15:0] == 16'h0) ? 1 : int'(v[15:0]);
    endtask

    task automatic wait_cyc(input int unsigned target);
        while (cyc < target) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic wait_idle(input int max_cyc);
        logic [31:0] r;
        int n;
        n = 0;
        rd(A_STAT, r);
        while ((r[0] || !r[2]) && n < max_cyc) begin
            @(posedge clock);
            #1;
            rd(A_STAT, r);
            n++;
        end
        if (n >= max_cyc) begin
            checks++;
            errors++;
            $display("FAIL wait_idle: still busy after %0d cycles, status %h", n, r);
        end
    endtask

    // Burst of k back-to-back DATA writes into an idle, empty block.
    // One byte leaves immediately, so at most FIFO depth + 1 are accepted.
    task automatic burst(input int k);
        logic [31:0] r;
        logic [7:0]  b;
        int          acc;
        int          lvl;
        int          exp_st;
        acc = (k < 5) ? k : 5;
        starts.delete();
        for (int i = 0; i < k; i++) begin
            b = 8'($urandom);
            if (i < acc) exp_q.push_back('{data: b, div: cur_div});
            wr(A_DATA, {24'h0, b});
        end
        lvl    = (k == 1) ? 1 : acc - 1;
        exp_st = ((k > 1) ? 1 : 0) | ((lvl == 4) ? 2 : 0) | ((k > 5) ? 8 : 0) | (lvl << 8);
        rd(A_STAT, r);
        chk("burst_status", r, 32'(exp_st));
        wait_idle(acc * NB * cur_div + 20);
        rd(A_STAT, r);
        chk("burst_done_status", r, (k > 5) ? 32'hC : 32'h4);
        chk("burst_frame_count", 32'(starts.size()), 32'(acc));
        for (int i = 1; i < starts.size(); i++) begin
            chk("burst_no_gap", starts[i] - starts[i-1], 32'(NB * cur_div));
        end
    endtask

    // Line monitor: checks every cycle of each frame against the queue head.
    initial begin : monitor
        frame_t     f;
        int         bad;
        logic [7:0] got;
        bit         aborted;
        forever begin
            @(negedge clock);
            if (reset_n && tx === 1'b0) begin
                starts.push_back(cyc);
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_frame: start bit at cycle %0d, expected idle line", cyc);
                    repeat (NB * cur_div - 1) @(negedge clock);
                end else begin
                    f       = exp_q.pop_front();
                    bad     = 0;
                    got     = 8'h0;
                    aborted = 1'b0;
                    for (int i = 0; i < NB * f.div; i++) begin
                        if (i > 0) @(negedge clock);
                        if (!reset_n) begin
                            aborted = 1'b1;
                            break;
                        end
                        if (tx !== exp_level(f.data, i / f.div)) bad++;
                        if ((i % f.div) == f.div / 2 && i / f.div >= 1 && i / f.div <= 8)
                            got[i / f.div - 1] = tx;
                    end
                    checks++;
                    if (aborted) begin
                        if (!abort_ok) begin
                            errors++;
                            $display("FAIL frame_abort: frame cut by reset, expected complete byte %h", f.data);
                        end
                    end else if (bad != 0) begin
                        errors++;
                        $display("FAIL frame: got byte %h with %0d wrong bit-cycles, expected byte %h at %0d cycles/bit",
                                 got, bad, f.data, f.div);
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL timeout: simulation did not complete, expected finish");
        $fatal(1, "timeout");
    end

    initial begin : stim
        logic [31:0] r;
        logic [7:0]  b;
        int unsigned n0;

        bus.bus_address    = 32'h0;
        bus.bus_write_data = 32'h0;
        bus.bus_write      = 1'b0;
        bus.bus_read       = 1'b0;
        repeat (3) @(posedge clock);
        #3 reset_n = 1'b1;
        @(posedge clock);
        #1;

        rd(A_STAT, r);  chk("reset_status", r, 32'h4);
        rd(A_DIV, r);   chk("reset_divisor", r, 32'd868);
        chk("reset_tx", {31'h0, tx}, 32'h1);

        // Single 0x55 frame at 4 cycles/bit: latency and BUSY duration.
        wr_div(4);
        exp_q.push_back('{data: 8'h55, div: 4});
        wr(A_DATA, 32'h55);
        n0 = cyc;
        @(negedge clock);
        chk("tx_before_pop", {31'h0, tx}, 32'h1);
        @(negedge clock);
        chk("tx_falls_after_pop", {31'h0, tx}, 32'h0);
        wait_cyc(n0 + 40);
        rd(A_STAT, r);  chk("busy_at_40", {31'h0, r[0]}, 32'h1);
        @(posedge clock); #1;
        rd(A_STAT, r);  chk("idle_at_41", r, 32'h4);

        // Six writes into depth-4 FIFO at 2 cycles/bit: one overrun.
        wr_div(2);
        burst(6);
        wr(A_STAT, 32'h8);
        rd(A_STAT, r);  chk("overrun_clear", r, 32'h4);
        wr_div(0);
        rd(A_DIV, r);   chk("divisor_zero_as_one", r, 32'h1);

        // Randomised bursts and divisors.
        repeat (5) begin
            wr_div(32'($urandom_range(1, 4)));
            burst($urandom_range(1, 7));
            wr(A_STAT, 32'h8);
            rd(A_STAT, r);  chk("round_clear", r, 32'h4);
        end

        // Reset during data bit 3 aborts the frame and flushes the FIFO.
        wr_div(4);
        b = 8'($urandom);
        exp_q.push_back('{data: b, div: 4});
        wr(A_DATA, {24'h0, b});
        wr(A_DATA, {24'h0, ~b});
        n0 = cyc;
        wait_cyc(n0 + 17);
        #2;
        abort_ok = 1'b1;
        reset_n  = 1'b0;
        #1;
        chk("tx_high_in_reset", {31'h0, tx}, 32'h1);
        exp_q.delete();
        @(negedge clock);
        @(posedge clock);
        #3 reset_n = 1'b1;
        @(posedge clock); #1;
        abort_ok = 1'b0;
        cur_div  = 868;
        starts.delete();
        rd(A_STAT, r);  chk("status_after_reset", r, 32'h4);
        rd(A_DIV, r);   chk("divisor_after_reset", r, 32'd868);
        repeat (60) @(posedge clock);
        #1;
        chk("no_frame_after_reset", 32'(starts.size()), 32'h0);

        // Unmapped offsets and addresses outside the window.
        rd(BASE + 32'hC, r);       chk("read_ofs_c", r, 32'h0);
        rd(32'h2000_0004, r);      chk("read_outside", r, 32'h0);
        rd(BASE + 32'h14, r);      chk("read_next_window", r, 32'h0);
        bus.bus_address = A_STAT;
        #1;
        chk("no_read_strobe", bus.bus_read_data, 32'h0);
        wr(BASE + 32'hC, 32'h5);
        wr(32'h2000_0008, 32'h7);
        wr(32'h2000_0000, 32'hAA);
        wr(BASE + 32'h18, 32'h3);
        repeat (20) @(posedge clock);
        #1;
        rd(A_DIV, r);   chk("div_unchanged", r, 32'd868);
        rd(A_STAT, r);  chk("status_unchanged", r, 32'h4);
        chk("no_frame_from_stray", 32'(starts.size()), 32'h0);
        chk("exp_queue_drained", 32'(exp_q.size()), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/bus_uart_tx.md
# bus_uart_tx

Memory-mapped UART transmitter on the core's data bus, downstream of the core's load/store port. It decodes `bus_address` against a base address, accepts byte writes into a small TX FIFO, and serialises bytes 8N1 on `tx` at a programmable bit period. Reads are combinational so single-cycle loads complete in the same cycle; all register writes take effect on the rising clock edge.

## Interface
- `BASE_ADDR`, 32'h1000_0000, register window base; 16-byte aligned.
- `FIFO_DEPTH`, 4, TX FIFO entries; power of two, ≥2.
- `DEFAULT_DIVISOR`, 16'd868, reset value of the divisor (clocks per bit).
- `clock`  in  1  rising-edge clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `bus_address`  in  32  byte address from the core.
- `bus_write_data`  in  32  store data.
- `bus_write`  in  1  store strobe.
- `bus_read`  in  1  load strobe.
- `bus_read_data`  out  32  load data; 0 when not selected.
- `tx`  out  1  serial output, idle high.

## Operation
- Select: `bus_address[31:4] == BASE_ADDR[31:4]`. Offset `bus_address[3:0]`: 0x0 DATA, 0x4 STATUS, 0x8 DIVISOR; other offsets read 0, writes ignored.
- DATA write: pushes `bus_write_data[7:0]` if FIFO not full at the start of the cycle. If full, the byte is dropped and sticky OVERRUN is set, even if a pop occurs in the same cycle. DATA reads 0.
- STATUS read: [0] BUSY (FSM not IDLE), [1] FULL, [2] EMPTY, [3] OVERRUN, [15:8] FIFO level, other bits 0. Writing 1 to bit 3 clears OVERRUN. A same-cycle overrun takes priority over the clear.
- DIVISOR read/write uses bits [15:0]. A written value of 0 is stored as 1. The divisor is sampled at the start of each bit.
- `bus_read_data` is combinational: selected register when `bus_read && select`, else 32'h0, so it can be OR-combined with other slaves.
- FSM states: IDLE → START → DATA (8 bits, LSB first) → [PARITY] → STOP.
  - IDLE pops the FIFO head when the FIFO is non-empty.
  - STOP expiry goes to START with an immediate pop if the FIFO is non-empty, otherwise to IDLE.
- Bit timer loads `divisor-1` on entry to each bit, decrements to 0, then advances.
- Line levels: `tx` = 0 in START, data bit in DATA, 1 in STOP and IDLE.

## Timing
- Reset values:
  - `tx` = 1, FSM IDLE, FIFO empty (level 0), OVERRUN = 0, divisor = `DEFAULT_DIVISOR`.
  - `bus_read_data` is 0 unless selected and read.
- Reset mid-frame aborts the frame immediately: `tx` goes to 1 asynchronously and FIFO contents are discarded.
- Write-to-start latency: a DATA write at edge N into an idle, empty block pops at edge N+1, so `tx` falls after edge N+1.
- Frame length is 10×divisor cycles (11× with parity).
- Back-to-back frames have no idle gap.
- Status latency: STATUS reflects a write or pop from edge N in the cycle after edge N; there is no read-side latency.

## Configuration
- `BUS_UART_TX_PARITY_EN` defined:
  - Adds a PARITY state between DATA and STOP.
  - Parity bit = even parity (XOR of the 8 data bits).
  - DIVISOR bit 16 selects odd parity when 1; reset value 0.
- Undefined: no PARITY state, frame is 8N1, DIVISOR bit 16 reads 0 and ignores writes.

## Structure
- Package `bus_uart_pkg` holds:
  - Register offsets `UART_DATA_OFS`, `UART_STATUS_OFS`, `UART_DIV_OFS`.
  - STATUS bit positions.
  - FSM state enum `uart_tx_state_t`.
- Sub-module `sync_fifo`: parameterised width and depth, push/pop/full/empty/level, async active-low reset; reusable for a future RX block.

## Test plan
- Reset, then read STATUS → 32'h0000_0004 (EMPTY); read DIVISOR → 868; `tx` = 1.
- Write DIVISOR = 4, then DATA = 0x55:
  - `tx` falls one cycle after the write edge.
  - Line pattern is 0,1,0,1,0,1,0,1,0,1, with each bit exactly 4 cycles.
  - BUSY clears after 40 cycles.
- Write DIVISOR = 2, then 6 DATA writes in consecutive cycles (depth 4):
  - First byte pops immediately; the next 4 fill the FIFO.
  - The 6th write is dropped and OVERRUN = 1.
  - 5 frames are sent back-to-back with no idle gap.
- Write STATUS = 0x8 → OVERRUN clears. Write DIVISOR = 0 → reads back 1.
- Assert `reset_n` low in the middle of DATA bit 3:
  - `tx` = 1 immediately.
  - After release, STATUS = 0x4 and no further frame is sent.
- Read unmapped offset 0xC and an address outside the window with `bus_read` = 1 → `bus_read_data` = 0; a write there has no effect on any register.
